pwm_gen_core: RTL

PWM timing core of the pwm_gen v2.0 AXI4-Lite peripheral. Sits directly downstream of the AXI4-Lite slave register file and consumes its four 32-bit slave registers (slv_reg0..3) plus the register write strobe. It produces one PWM output with:
- a prescaled timebase;
- period and duty values double-buffered at the period boundary;
- selectable polarity;
- an optional one-shot burst mode with done status readable back over AXI.

---
 rtl/pwm_gen_pkg.sv | 34 +++
 rtl/pwm_gen_if.sv | 26 ++
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_gen_core.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared types and constants for the pwm_gen timing core: FSM states,
// control-register bit positions, prescaler/burst field ranges and shadow layout.
package pwm_gen_pkg;

   localparam int unsigned C_S_AXI_DATA_WIDTH = 32;

   localparam int unsigned EN_BIT      = 0;
   localparam int unsigned POL_BIT     = 1;
   localparam int unsigned ONESHOT_BIT = 2;

   localparam int unsigned PRESC_LSB = 0;
   localparam int unsigned PRESC_MSB = 15;
   localparam int unsigned BURST_LSB = 16;
   localparam int unsigned BURST_MSB = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] period;
      logic [31:0] duty;
      logic [15:0] presc;
      logic [15:0] burst;
   } shadow_t;

   // A burst count of zero behaves as a single period.
   function automatic logic [15:0] burst_target(input logic [15:0] n);
      return (n == '0) ? 16'd1 : n;
   endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Register-side bundle between the AXI4-Lite slave register file and the PWM core:
// configuration registers and write strobe in, status readback out.
interface pwm_gen_if;
   import pwm_gen_pkg::*;

   logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_i;
   logic [C_S_AXI_DATA_WIDTH-1:0] period_i;
   logic [C_S_AXI_DATA_WIDTH-1:0] duty_i;
   logic [C_S_AXI_DATA_WIDTH-1:0] presc_i;
   logic                          update_i;
   logic                          tick_o;
   logic                          busy_o;
   logic                          done_o;
   logic [C_S_AXI_DATA_WIDTH-1:0] cnt_o;

   modport master (
      output ctrl_i, period_i, duty_i, presc_i, update_i,
      input  tick_o, busy_o, done_o, cnt_o
   );

   modport slave (
      input  ctrl_i, period_i, duty_i, presc_i, update_i,
      output tick_o, busy_o, done_o, cnt_o
   );

endinterface

// File: rtl/pwm_prescaler.sv
// Timebase prescaler: s_cnt runs 0..S while enabled and fires a tick on the
// clock where s_cnt equals S, so S=0 ticks every clock.
module pwm_prescaler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [15:0] presc_i,
   output logic        tick_o
);

   logic [15:0] s_cnt_q, s_cnt_d;

   assign tick_o = en_i && (s_cnt_q == presc_i);

   always_comb begin
      s_cnt_d = s_cnt_q;
      if (clr_i) begin
         s_cnt_d = '0;
      end else if (en_i) begin
         s_cnt_d = tick_o ? '0 : s_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_cnt_q <= '0;
      end else begin
         s_cnt_q <= s_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_gen_core.sv
// PWM timing core of pwm_gen: IDLE/RUN/DONE control, period counter, double-buffered
// period/duty/prescaler/burst shadows, duty compare and registered outputs.
module pwm_gen_core
   import pwm_gen_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
   input  logic     s00_axi_aclk,
   input  logic     s00_axi_aresetn,
   pwm_gen_if.slave regs,
   output logic     pwm_o
);

   state_e  state_q, state_d;
   shadow_t sh_q, sh_d, sh_in;

   logic                          pend_q, pend_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] p_cnt_q, p_cnt_d;
   logic [15:0]                   b_cnt_q, b_cnt_d;
   logic                          pwm_q, pwm_d;
   logic                          tick_q, tick_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   logic en, pol, oneshot;
   logic ts_tick, psc_clr, psc_en;
   logic last_cnt, burst_last, period_end;
   logic unused_ctrl;

   assign en          = regs.ctrl_i[EN_BIT];
   assign pol         = regs.ctrl_i[POL_BIT];
   assign oneshot     = regs.ctrl_i[ONESHOT_BIT];
   assign unused_ctrl = ^regs.ctrl_i[C_S_AXI_DATA_WIDTH-1:3];

   assign sh_in.period = regs.period_i;
   assign sh_in.duty   = regs.duty_i;
   assign sh_in.presc  = regs.presc_i[PRESC_MSB:PRESC_LSB];
   assign sh_in.burst  = regs.presc_i[BURST_MSB:BURST_LSB];

   // Prescaler restarts from 0 on RUN entry and is held clear outside RUN.
   assign psc_en  = (state_q == RUN);
   assign psc_clr = (state_q != RUN) || (state_d != RUN);

   pwm_prescaler u_prescaler (
      .clk     (s00_axi_aclk),
      .rst_n   (s00_axi_aresetn),
      .clr_i   (psc_clr),
      .en_i    (psc_en),
      .presc_i (sh_q.presc),
      .tick_o  (ts_tick)
   );

   assign last_cnt   = (p_cnt_q == sh_q.period);
   assign burst_last = ({1'b0, b_cnt_q} + 17'd1) >= {1'b0, burst_target(sh_q.burst)};
   assign period_end = (state_q == RUN) && en && ts_tick && last_cnt;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      pend_d  = pend_q;
      p_cnt_d = p_cnt_q;
      b_cnt_d = b_cnt_q;

      unique case (state_q)
         IDLE: begin
            p_cnt_d = '0;
            b_cnt_d = '0;
            if (en) begin
               state_d = RUN;
               sh_d    = sh_in;
               pend_d  = 1'b0;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               p_cnt_d = '0;
               b_cnt_d = '0;
            end else begin
               pend_d = pend_q | regs.update_i;
               if (period_end) begin
                  p_cnt_d = '0;
                  b_cnt_d = b_cnt_q + 16'd1;
                  // A write landing on the boundary clock takes effect immediately.
                  if (pend_q || regs.update_i) begin
                     sh_d   = sh_in;
                     pend_d = 1'b0;
                  end
                  if (oneshot && burst_last) begin
                     state_d = DONE;
                  end
               end else if (ts_tick) begin
                  p_cnt_d = p_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (!en) begin
               state_d = IDLE;
               p_cnt_d = '0;
               b_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pwm_d  = pol;
      if (state_q == RUN) begin
         pwm_d = (p_cnt_q < sh_q.duty) ^ pol;
      end
      tick_d = period_end;
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q <= IDLE;
         sh_q    <= '0;
         pend_q  <= 1'b0;
         p_cnt_q <= '0;
         b_cnt_q <= '0;
         pwm_q   <= 1'b0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         pend_q  <= pend_d;
         p_cnt_q <= p_cnt_d;
         b_cnt_q <= b_cnt_d;
         pwm_q   <= pwm_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pwm_o       = pwm_q;
   assign regs.tick_o = tick_q;
   assign regs.busy_o = busy_q;
   assign regs.done_o = done_q;
   assign regs.cnt_o  = p_cnt_q;

endmodule
